// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// word width and the request address legality check.
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misaligned, or any byte-address bit above the backing array is set.
    function automatic logic addr_err(input logic [31:0] addr, input int depth_log2);
        logic [31:0] high_bits;
        high_bits = addr >> (depth_log2 + 2);
        return (addr[1:0] != 2'b00) || (high_bits != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store initiator and the memory responder.
interface dmem_responder_if;

    logic                        req_valid;
    logic                        req_write;
    logic [mem_pkg::WORD_W-1:0]  req_addr;
    logic [mem_pkg::WORD_W-1:0]  req_wdata;
    logic                        req_ready;
    logic                        rsp_valid;
    logic [mem_pkg::WORD_W-1:0]  rsp_rdata;
    logic                        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ram_1rw.sv
// Single-port word array: synchronous write, combinational read, no reset so
// contents survive a responder reset.
module ram_1rw
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [WORD_W-1:0]     wdata,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

    // Store port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: accepts one request in IDLE, waits
// LATENCY cycles, then pulses a single registered response.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic               clk,
    input  logic               reset,
    dmem_responder_if.slave    bus
);

    localparam logic [2:0] CNT_LOAD = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    state_t              state_r;
    state_t              state_s;
    logic [2:0]          cnt_r;
    logic [2:0]          cnt_s;
    logic                write_r;
    logic [WORD_W-1:0]   addr_r;
    logic [WORD_W-1:0]   wdata_r;

    logic                ready_r;
    logic                rsp_valid_r;
    logic                rsp_err_r;
    logic [WORD_W-1:0]   rsp_rdata_r;

    logic                accept_s;
    logic                cur_write_s;
    logic [WORD_W-1:0]   cur_addr_s;
    logic                cur_err_s;
    logic                ram_we_s;
    logic [WORD_W-1:0]   ram_rdata_s;

    assign accept_s = (state_r == IDLE) && bus.req_valid;

    // With LATENCY=1 the response is prepared on the accept edge, so the
    // live request is used before it has been latched.
    assign cur_write_s = (state_r == IDLE) ? bus.req_write : write_r;
    assign cur_addr_s  = (state_r == IDLE) ? bus.req_addr  : addr_r;
    assign cur_err_s   = addr_err(cur_addr_s, DEPTH_LOG2);
    assign ram_we_s    = (state_r == RESP) && cur_write_s && !cur_err_s && !reset;

    ram_1rw #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .addr  (cur_addr_s[DEPTH_LOG2+1:2]),
        .wdata (wdata_r),
        .rdata (ram_rdata_s)
    );

    // Next-state and wait-counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 1) begin
                        state_s = RESP;
                        cnt_s   = 3'd0;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = CNT_LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 3'd0) begin
                    state_s = RESP;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // State, request capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 3'd0;
            write_r     <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            ready_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            if (accept_s) begin
                write_r <= bus.req_write;
                addr_r  <= bus.req_addr;
                wdata_r <= bus.req_wdata;
            end
            ready_r     <= (state_s == IDLE);
            rsp_valid_r <= (state_s == RESP);
            rsp_err_r   <= (state_s == RESP) && cur_err_s;
            rsp_rdata_r <= ((state_s == RESP) && !cur_write_s && !cur_err_s) ? ram_rdata_s : '0;
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Three responders (LATENCY 1, 2, 3) share one stimulus stream and are checked
// against a word-array model with arithmetic timing expectations.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat [3] = '{1, 2, 3};
  logic [31:0] mem_m [256];

  logic        ready_a [3];
  logic [33:0] rsp_a   [3];

  dmem_responder_if if_l1 ();
  dmem_responder_if if_l2 ();
  dmem_responder_if if_l3 ();

  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(if_l1.slave));
  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(if_l2.slave));
  dmem_responder #(.DEPTH_LOG2(8), .LATENCY(3)) u_l3 (.clk(clk), .reset(reset), .bus(if_l3.slave));

  assign if_l1.req_valid = req_valid;
  assign if_l1.req_write = req_write;
  assign if_l1.req_addr  = req_addr;
  assign if_l1.req_wdata = req_wdata;
  assign if_l2.req_valid = req_valid;
  assign if_l2.req_write = req_write;
  assign if_l2.req_addr  = req_addr;
  assign if_l2.req_wdata = req_wdata;
  assign if_l3.req_valid = req_valid;
  assign if_l3.req_write = req_write;
  assign if_l3.req_addr  = req_addr;
  assign if_l3.req_wdata = req_wdata;

  assign ready_a[0] = if_l1.req_ready;
  assign ready_a[1] = if_l2.req_ready;
  assign ready_a[2] = if_l3.req_ready;
  assign rsp_a[0]   = {if_l1.rsp_valid, if_l1.rsp_err, if_l1.rsp_rdata};
  assign rsp_a[1]   = {if_l2.rsp_valid, if_l2.rsp_err, if_l2.rsp_rdata};
  assign rsp_a[2]   = {if_l3.rsp_valid, if_l3.rsp_err, if_l3.rsp_rdata};

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a);
    return (a[1:0] != 2'd0) || (a >= 32'h400);
  endfunction

  // All responders idle on entry; the response must appear exactly lat cycles
  // after the accept edge and ready must return the cycle after that.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic        e;
    logic [33:0] exp;
    e = model_err(a);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        exp = 34'd0;
        if (k == lat[i]) exp = {1'b1, e, (w || e) ? 32'd0 : mem_m[a[9:2]]};
        check_eq($sformatf("rsp L%0d a=%h k=%0d", lat[i], a, k), 64'(rsp_a[i]), 64'(exp));
        check_eq($sformatf("ready L%0d k=%0d", lat[i], k), 64'(ready_a[i]), 64'(k > lat[i]));
      end
      @(negedge clk);
    end
    if (w && !e) mem_m[a[9:2]] = d;
  endtask

  task automatic check_idle(input string tag);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s ready L%0d", tag, lat[i]), 64'(ready_a[i]), 64'd1);
      check_eq($sformatf("%s rsp L%0d", tag, lat[i]), 64'(rsp_a[i]), 64'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          r;

    // Reset with a simultaneous request: it must not be taken.
    reset     = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_idle("reset");
    reset     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    for (int idx = 0; idx < 256; idx++) txn(1'b1, 32'(idx * 4), $urandom);

    txn(1'b1, 32'h10, 32'hDEADBEEF);
    txn(1'b0, 32'h10, 32'h0);
    check_eq("model 0x10", 64'(mem_m[4]), 64'h0000_0000_DEAD_BEEF);

    txn(1'b0, 32'h13, 32'h0);
    txn(1'b1, 32'h400, 32'hCAFEF00D);
    txn(1'b0, 32'h000, 32'h0);
    txn(1'b1, 32'h3FC, 32'h0BADF00D);
    txn(1'b0, 32'h3FC, 32'h0);

    // Store aborted by reset while the responders are mid-transaction.
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h3FC;
    req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check_idle($sformatf("abort k=%0d", k));
      @(negedge clk);
    end
    txn(1'b0, 32'h3FC, 32'h0);

    txn(1'b1, 32'h20, 32'hA5A5A5A5);
    txn(1'b0, 32'h20, 32'h0);

    for (int n = 0; n < 150; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      a = {22'd0, 8'($urandom), 2'b00};
      else if (r < 8) a = ($urandom & 32'h3FF) | 32'h1;
      else            a = $urandom;
      txn(1'($urandom_range(0, 1)), a, $urandom);
    end

    // Back-to-back loads with req_valid held: one accept per lat+1 cycles.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h10;
    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 3; i++) begin
        check_eq($sformatf("burst ready L%0d k=%0d", lat[i], k),
                 64'(ready_a[i]), 64'((k % (lat[i] + 1)) == 0));
        check_eq($sformatf("burst rsp L%0d k=%0d", lat[i], k), 64'(rsp_a[i]),
                 ((k % (lat[i] + 1)) == lat[i]) ? 64'({2'b10, mem_m[4]}) : 64'd0);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_idle("drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
